alu_rs: RTL and testbench

- Reservation station and issue scheduler for the integer ALU.
- Accepts decoded ALU-class instructions from the dispatcher and holds them until both source operands are available.
- Operand values are captured from the common data bus (CDB) broadcasts.
- Each cycle, selects at most one ready entry and drives it into the combinational ALU through registered outputs.
- Sits between the decoder/ROB dispatch stage and the ALU; the ALU's result goes onto the CDB.

---
 rtl/alu_rs_pkg.sv | 23 ++
 rtl/alu_rs_pick.sv | 24 ++
 rtl/alu_rs.sv | 177 +++++++++++++++++
 tb/tb_alu_rs.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants for the integer ALU reservation station: default sizes,
// tag width and the ALU opcode encodings.
package alu_rs_pkg;

  localparam int RS_SZ_DEF      = 16;
  localparam int ROB_SZ_LOG_DEF = 4;
  localparam int OP_W_DEF       = 6;
  localparam int TAG_W_DEF      = ROB_SZ_LOG_DEF + 1;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: reports whether any mask bit is set and the
// index of the lowest set bit.
module alu_rs_pick #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit be the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds dispatched instructions until
// both operands arrive from the CDB, then issues one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SZ      = RS_SZ_DEF,
  parameter int ROB_SZ_LOG = ROB_SZ_LOG_DEF,
  parameter int OP_W       = OP_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  dis_flg,
  input  logic [OP_W-1:0]       dis_op,
  input  logic [31:0]           dis_vj,
  input  logic [31:0]           dis_vk,
  input  logic [ROB_SZ_LOG:0]   dis_qj,
  input  logic [ROB_SZ_LOG:0]   dis_qk,
  input  logic                  dis_qj_bsy,
  input  logic                  dis_qk_bsy,
  input  logic [31:0]           dis_imm,
  input  logic [31:0]           dis_pc,
  input  logic [ROB_SZ_LOG:0]   dis_rd,
  input  logic                  cdb_a_flg,
  input  logic [ROB_SZ_LOG:0]   cdb_a_rd,
  input  logic [31:0]           cdb_a_val,
  input  logic                  cdb_b_flg,
  input  logic [ROB_SZ_LOG:0]   cdb_b_rd,
  input  logic [31:0]           cdb_b_val,
  output logic                  rs_full,
  output logic                  out_run,
  output logic [31:0]           out_vj,
  output logic [31:0]           out_vk,
  output logic [31:0]           out_imm,
  output logic [31:0]           out_pc,
  output logic [OP_W-1:0]       out_op,
  output logic [ROB_SZ_LOG:0]   out_rd
);

  localparam int TAG_W = ROB_SZ_LOG + 1;
  localparam int IDX_W = $clog2(RS_SZ);

  logic [RS_SZ-1:0] busy, qj_bsy, qk_bsy;
  logic [OP_W-1:0]  op  [RS_SZ];
  logic [31:0]      vj  [RS_SZ];
  logic [31:0]      vk  [RS_SZ];
  logic [31:0]      imm [RS_SZ];
  logic [31:0]      pc  [RS_SZ];
  logic [TAG_W-1:0] qj  [RS_SZ];
  logic [TAG_W-1:0] qk  [RS_SZ];
  logic [TAG_W-1:0] rd  [RS_SZ];

  logic [RS_SZ-1:0] free_mask, ready_mask;
  logic             free_found, iss_found;
  logic [IDX_W-1:0] free_idx, iss_idx;
  logic             do_dis, do_iss;
  logic             run_q;

  assign free_mask  = ~busy;
  assign ready_mask = busy & ~qj_bsy & ~qk_bsy;
  assign rs_full    = &busy;

  alu_rs_pick #(.N(RS_SZ), .IDX_W(IDX_W)) u_pick_free (
    .mask  (free_mask),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_pick #(.N(RS_SZ), .IDX_W(IDX_W)) u_pick_iss (
    .mask  (ready_mask),
    .found (iss_found),
    .idx   (iss_idx)
  );

  assign do_dis = rdy_in & dis_flg & ~rs_full & free_found;
  assign do_iss = rdy_in & iss_found;

  // Per-entry tag matches against both broadcast ports; port a wins on a tie.
  logic [RS_SZ-1:0] j_hit_a, j_hit_b, k_hit_a, k_hit_b;
  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      j_hit_a[i] = cdb_a_flg && (qj[i] == cdb_a_rd);
      j_hit_b[i] = cdb_b_flg && (qj[i] == cdb_b_rd);
      k_hit_a[i] = cdb_a_flg && (qk[i] == cdb_a_rd);
      k_hit_b[i] = cdb_b_flg && (qk[i] == cdb_b_rd);
    end
  end

  // Operands of the incoming instruction after same-cycle CDB capture.
  logic [31:0] cap_vj, cap_vk;
  logic        cap_jb, cap_kb;
  always_comb begin
    cap_vj = dis_vj;
    cap_jb = dis_qj_bsy;
    cap_vk = dis_vk;
    cap_kb = dis_qk_bsy;
    if (dis_qj_bsy && cdb_a_flg && (cdb_a_rd == dis_qj)) begin
      cap_vj = cdb_a_val;
      cap_jb = 1'b0;
    end else if (dis_qj_bsy && cdb_b_flg && (cdb_b_rd == dis_qj)) begin
      cap_vj = cdb_b_val;
      cap_jb = 1'b0;
    end
    if (dis_qk_bsy && cdb_a_flg && (cdb_a_rd == dis_qk)) begin
      cap_vk = cdb_a_val;
      cap_kb = 1'b0;
    end else if (dis_qk_bsy && cdb_b_flg && (cdb_b_rd == dis_qk)) begin
      cap_vk = cdb_b_val;
      cap_kb = 1'b0;
    end
  end

  // Entry state. The dispatch slot is always a free one and the issue slot a
  // busy one, so the two writes never target the same entry.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      busy   <= '0;
      qj_bsy <= '0;
      qk_bsy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SZ; i++) begin
        if (busy[i] && qj_bsy[i] && (j_hit_a[i] || j_hit_b[i])) begin
          vj[i]     <= j_hit_a[i] ? cdb_a_val : cdb_b_val;
          qj_bsy[i] <= 1'b0;
        end
        if (busy[i] && qk_bsy[i] && (k_hit_a[i] || k_hit_b[i])) begin
          vk[i]     <= k_hit_a[i] ? cdb_a_val : cdb_b_val;
          qk_bsy[i] <= 1'b0;
        end
      end
      if (do_iss) begin
        busy[iss_idx] <= 1'b0;
      end
      if (do_dis) begin
        busy[free_idx]   <= 1'b1;
        op[free_idx]     <= dis_op;
        vj[free_idx]     <= cap_vj;
        vk[free_idx]     <= cap_vk;
        qj[free_idx]     <= dis_qj;
        qk[free_idx]     <= dis_qk;
        qj_bsy[free_idx] <= cap_jb;
        qk_bsy[free_idx] <= cap_kb;
        imm[free_idx]    <= dis_imm;
        pc[free_idx]     <= dis_pc;
        rd[free_idx]     <= dis_rd;
      end
    end
  end

  // Issue registers. While stalled the pending issue is held and masked, so
  // the ALU sees it once rdy_in returns.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      run_q   <= 1'b0;
      out_vj  <= '0;
      out_vk  <= '0;
      out_imm <= '0;
      out_pc  <= '0;
      out_op  <= '0;
      out_rd  <= '0;
    end else if (rdy_in) begin
      run_q <= iss_found;
      if (iss_found) begin
        out_vj  <= vj[iss_idx];
        out_vk  <= vk[iss_idx];
        out_imm <= imm[iss_idx];
        out_pc  <= pc[iss_idx];
        out_op  <= op[iss_idx];
        out_rd  <= rd[iss_idx];
      end
    end
  end

  assign out_run = run_q & rdy_in;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: table-driven dispatch vectors, directed corner sequences
// and a randomized run, all scored against a slot-level behavioural model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N  = 16;
  localparam int TW = 5;
  localparam int OW = 6;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clr_in, dis_flg;
  logic [OW-1:0] dis_op;
  logic [31:0]   dis_vj, dis_vk, dis_imm, dis_pc;
  logic [TW-1:0] dis_qj, dis_qk, dis_rd;
  logic          dis_qj_bsy, dis_qk_bsy;
  logic          cdb_a_flg, cdb_b_flg;
  logic [TW-1:0] cdb_a_rd, cdb_b_rd;
  logic [31:0]   cdb_a_val, cdb_b_val;
  logic          rs_full, out_run;
  logic [31:0]   out_vj, out_vk, out_imm, out_pc;
  logic [OW-1:0] out_op;
  logic [TW-1:0] out_rd;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .dis_flg(dis_flg), .dis_op(dis_op), .dis_vj(dis_vj), .dis_vk(dis_vk),
    .dis_qj(dis_qj), .dis_qk(dis_qk), .dis_qj_bsy(dis_qj_bsy), .dis_qk_bsy(dis_qk_bsy),
    .dis_imm(dis_imm), .dis_pc(dis_pc), .dis_rd(dis_rd),
    .cdb_a_flg(cdb_a_flg), .cdb_a_rd(cdb_a_rd), .cdb_a_val(cdb_a_val),
    .cdb_b_flg(cdb_b_flg), .cdb_b_rd(cdb_b_rd), .cdb_b_val(cdb_b_val),
    .rs_full(rs_full), .out_run(out_run), .out_vj(out_vj), .out_vk(out_vk),
    .out_imm(out_imm), .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    bit            busy;
    bit            jw;
    bit            kw;
    logic [OW-1:0] op;
    logic [31:0]   vj, vk, imm, pc;
    logic [TW-1:0] qj, qk, rd;
  } slot_t;

  slot_t         m_slot [N];
  bit            m_run = 1'b0;
  logic [31:0]   m_vj, m_vk, m_imm, m_pc;
  logic [OW-1:0] m_op;
  logic [TW-1:0] m_rd;

  function automatic bit bcast(input logic [TW-1:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb_a_flg && cdb_a_rd == tag) begin
      val = cdb_a_val;
      return 1'b1;
    end
    if (cdb_b_flg && cdb_b_rd == tag) begin
      val = cdb_b_val;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    int          iss;
    int          dst;
    int          used;
    logic [31:0] v;
    slot_t       s;
    if (rst_in || clr_in) begin
      for (int i = 0; i < N; i++) m_slot[i].busy = 1'b0;
      m_run = 1'b0;
      m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_op = '0; m_rd = '0;
      return;
    end
    if (!rdy_in) return;
    iss = -1; dst = -1; used = 0;
    for (int i = 0; i < N; i++) begin
      if (m_slot[i].busy) used++;
      else if (dst < 0) dst = i;
      if (iss < 0 && m_slot[i].busy && !m_slot[i].jw && !m_slot[i].kw) iss = i;
    end
    m_run = (iss >= 0);
    if (iss >= 0) begin
      m_vj = m_slot[iss].vj; m_vk = m_slot[iss].vk; m_imm = m_slot[iss].imm;
      m_pc = m_slot[iss].pc; m_op = m_slot[iss].op; m_rd = m_slot[iss].rd;
      m_slot[iss].busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_slot[i].busy && m_slot[i].jw && bcast(m_slot[i].qj, v)) begin
        m_slot[i].vj = v; m_slot[i].jw = 1'b0;
      end
      if (m_slot[i].busy && m_slot[i].kw && bcast(m_slot[i].qk, v)) begin
        m_slot[i].vk = v; m_slot[i].kw = 1'b0;
      end
    end
    if (dis_flg && used < N) begin
      s.busy = 1'b1; s.op = dis_op; s.imm = dis_imm; s.pc = dis_pc; s.rd = dis_rd;
      s.qj = dis_qj; s.qk = dis_qk; s.vj = dis_vj; s.vk = dis_vk;
      s.jw = dis_qj_bsy; s.kw = dis_qk_bsy;
      if (s.jw && bcast(dis_qj, v)) begin s.vj = v; s.jw = 1'b0; end
      if (s.kw && bcast(dis_qk, v)) begin s.vk = v; s.kw = 1'b0; end
      m_slot[dst] = s;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int used;
    used = 0;
    for (int i = 0; i < N; i++) if (m_slot[i].busy) used++;
    chk("m_rs_full", 64'(rs_full), 64'(used == N));
    chk("m_out_run", 64'(out_run), 64'(m_run && rdy_in));
    chk("m_out_vj", 64'(out_vj), 64'(m_vj));
    chk("m_out_vk", 64'(out_vk), 64'(m_vk));
    chk("m_out_imm", 64'(out_imm), 64'(m_imm));
    chk("m_out_pc", 64'(out_pc), 64'(m_pc));
    chk("m_out_op_rd", 64'({out_op, out_rd}), 64'({m_op, m_rd}));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; dis_flg = 1'b0;
    cdb_a_flg = 1'b0; cdb_b_flg = 1'b0;
  endtask

  task automatic drive_dis(input logic [OW-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                           input logic jb, input logic kb, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [TW-1:0] rd);
    dis_flg = 1'b1; dis_op = op; dis_vj = vj; dis_vk = vk; dis_qj = qj; dis_qk = qk;
    dis_qj_bsy = jb; dis_qk_bsy = kb; dis_imm = imm; dis_pc = pc; dis_rd = rd;
  endtask

  task automatic drive_cdb_a(input logic [TW-1:0] tag, input logic [31:0] val);
    cdb_a_flg = 1'b1; cdb_a_rd = tag; cdb_a_val = val;
  endtask

  task automatic drive_cdb_b(input logic [TW-1:0] tag, input logic [31:0] val);
    cdb_b_flg = 1'b1; cdb_b_rd = tag; cdb_b_val = val;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [OW-1:0] op;
    logic [31:0]   vj, vk;
    logic [TW-1:0] qj, qk;
    logic          jb, kb;
    logic          a_flg;
    logic [TW-1:0] a_rd;
    logic [31:0]   a_val;
    logic          b_flg;
    logic [TW-1:0] b_rd;
    logic [31:0]   b_val;
    logic [TW-1:0] rd;
    logic [31:0]   exp_vj, exp_vk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [OW-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                               input logic jb, input logic kb,
                               input logic a_flg, input logic [TW-1:0] a_rd, input logic [31:0] a_val,
                               input logic b_flg, input logic [TW-1:0] b_rd, input logic [31:0] b_val,
                               input logic [TW-1:0] rd, input logic [31:0] exp_vj,
                               input logic [31:0] exp_vk);
    vec_t v;
    v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk; v.jb = jb; v.kb = kb;
    v.a_flg = a_flg; v.a_rd = a_rd; v.a_val = a_val;
    v.b_flg = b_flg; v.b_rd = b_rd; v.b_val = b_val;
    v.rd = rd; v.exp_vj = exp_vj; v.exp_vk = exp_vk;
    return v;
  endfunction

  initial begin
    logic [TW-1:0] ta, tb;
    logic [OW-1:0] rop;

    idle();
    dis_op = '0; dis_vj = '0; dis_vk = '0; dis_qj = '0; dis_qk = '0; dis_rd = '0;
    dis_qj_bsy = 1'b0; dis_qk_bsy = 1'b0; dis_imm = '0; dis_pc = '0;
    cdb_a_rd = '0; cdb_b_rd = '0; cdb_a_val = '0; cdb_b_val = '0;

    vecs.push_back(mkv(OP_OR, 32'h0000_0123, 32'h0000_0456, 5'd0, 5'd0, 1'b0, 1'b0,
                       1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 32'h0000_0123, 32'h0000_0456));
    vecs.push_back(mkv(OP_SUB, 32'h0000_0064, 32'h0, 5'd0, 5'd4, 1'b0, 1'b1,
                       1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 5'd2, 32'h0000_0064, 32'hDEAD_BEEF));
    vecs.push_back(mkv(OP_XOR, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1, 1'b1,
                       1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022, 5'd5, 32'h0000_0011, 32'h0000_0022));
    vecs.push_back(mkv(OP_AND, 32'h0, 32'h0, 5'd6, 5'd6, 1'b1, 1'b1,
                       1'b1, 5'd6, 32'h0000_AAAA, 1'b1, 5'd6, 32'h0000_BBBB, 5'd6, 32'h0000_AAAA, 32'h0000_AAAA));
    vecs.push_back(mkv(OP_SLT, 32'h0000_0321, 32'h0000_0009, 5'd5, 5'd0, 1'b0, 1'b0,
                       1'b1, 5'd5, 32'h0000_0999, 1'b0, 5'd0, 32'h0, 5'd7, 32'h0000_0321, 32'h0000_0009));
    vecs.push_back(mkv(OP_SLL, 32'h0, 32'h0000_0003, 5'd8, 5'd0, 1'b1, 1'b0,
                       1'b1, 5'd9, 32'h0000_0777, 1'b1, 5'd8, 32'h0000_0055, 5'd8, 32'h0000_0055, 32'h0000_0003));

    // ---------------- reset ----------------
    rst_in = 1'b1;
    tick();
    tick();
    idle();
    chk("reset_out_run", 64'(out_run), 64'd0);
    chk("reset_rs_full", 64'(rs_full), 64'd0);
    chk("reset_out_vj", 64'(out_vj), 64'd0);

    // Ready ADD: two-cycle latency, slot freed after issue.
    drive_dis(OP_ADD, 32'd5, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0, 32'h10, 32'h100, 5'd3);
    tick();
    idle();
    chk("add_not_early", 64'(out_run), 64'd0);
    tick();
    chk("add_run", 64'(out_run), 64'd1);
    chk("add_vj", 64'(out_vj), 64'd5);
    chk("add_vk", 64'(out_vk), 64'd7);
    chk("add_rd", 64'(out_rd), 64'd3);
    tick();
    chk("add_freed", 64'(out_run), 64'd0);

    // Table: dispatch with same-cycle capture, expect issue two edges later.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_dis(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].qj, vecs[i].qk, vecs[i].jb, vecs[i].kb,
                32'h200 + 32'(i), 32'h2000 + 32'(i), vecs[i].rd);
      if (vecs[i].a_flg) drive_cdb_a(vecs[i].a_rd, vecs[i].a_val);
      if (vecs[i].b_flg) drive_cdb_b(vecs[i].b_rd, vecs[i].b_val);
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_run", i), 64'(out_run), 64'd1);
      chk($sformatf("vec%0d_vj", i), 64'(out_vj), 64'(vecs[i].exp_vj));
      chk($sformatf("vec%0d_vk", i), 64'(out_vk), 64'(vecs[i].exp_vk));
      chk($sformatf("vec%0d_op_rd", i), 64'({out_op, out_rd}), 64'({vecs[i].op, vecs[i].rd}));
      tick();
    end

    // Wakeup from CDB port b; no issue in the wake cycle itself.
    drive_dis(OP_SUB, 32'h0, 32'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'h0, 32'h300, 5'd9);
    tick();
    idle();
    tick();
    drive_cdb_b(5'd2, 32'd10);
    tick();
    idle();
    chk("wake_not_same_cycle", 64'(out_run), 64'd0);
    tick();
    chk("wake_run", 64'(out_run), 64'd1);
    chk("wake_vj", 64'(out_vj), 64'd10);
    tick();

    // Fill all entries blocked on tag 7, overflow dispatch, then drain in order.
    for (int i = 0; i < N; i++) begin
      drive_dis(OP_ADD, 32'h0, 32'(i), 5'd7, 5'd0, 1'b1, 1'b0, 32'h0, 32'h1000 + 32'(4 * i), 5'(i));
      exp_q.push_back(32'h1000 + 32'(4 * i));
      tick();
    end
    chk("fill_full", 64'(rs_full), 64'd1);
    drive_dis(OP_ADD, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0BAD, 5'd0);
    tick();
    chk("overflow_full", 64'(rs_full), 64'd1);
    chk("overflow_no_run", 64'(out_run), 64'd0);
    idle();
    drive_cdb_a(5'd7, 32'd77);
    tick();
    idle();
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("drain%0d_run", i), 64'(out_run), 64'd1);
      chk($sformatf("drain%0d_pc", i), 64'(out_pc), 64'(exp_q.pop_front()));
      if (i == 0) chk("drain_full_drop", 64'(rs_full), 64'd0);
    end
    chk("drain_vj", 64'(out_vj), 64'd77);
    tick();
    chk("drain_done", 64'(out_run), 64'd0);

    // Flush beats a concurrent dispatch and matching broadcast.
    for (int i = 0; i < 3; i++) begin
      drive_dis(OP_OR, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 1'b0, 32'h0, 32'h4000 + 32'(i), 5'd1);
      tick();
    end
    clr_in = 1'b1;
    drive_dis(OP_OR, 32'd1, 32'd2, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h5000, 5'd2);
    drive_cdb_a(5'd9, 32'h99);
    tick();
    idle();
    chk("clr_run", 64'(out_run), 64'd0);
    chk("clr_full", 64'(rs_full), 64'd0);
    chk("clr_out_pc", 64'(out_pc), 64'd0);
    drive_cdb_a(5'd9, 32'h99);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_no_issue", 64'(out_run), 64'd0);
    end

    // Stall: a ready entry waits out rdy_in=0, then issues on the next edge.
    drive_dis(OP_ADD, 32'h66, 32'h67, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h6000, 5'd4);
    tick();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_run", 64'(out_run), 64'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("stall_release_run", 64'(out_run), 64'd1);
    chk("stall_release_vj", 64'(out_vj), 64'h66);
    tick();
    chk("stall_done", 64'(out_run), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 9) == 0) rdy_in = 1'b0;
      if ($urandom_range(0, 63) == 0) clr_in = 1'b1;
      if ($urandom_range(0, 99) < 55) begin
        ta = TW'($urandom_range(0, 7));
        if (ta >= 5'd4) ta = ta + 5'd12;
        tb = TW'($urandom_range(0, 7));
        if (tb >= 5'd4) tb = tb + 5'd12;
        rop = OW'($urandom_range(0, 9));
        drive_dis(rop, $urandom, $urandom, ta, tb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, TW'($urandom_range(0, 31)));
      end
      ta = TW'($urandom_range(0, 7));
      if (ta >= 5'd4) ta = ta + 5'd12;
      if ($urandom_range(0, 99) < 30) drive_cdb_a(ta, $urandom);
      if ($urandom_range(0, 99) < 30) begin
        tb = TW'($urandom_range(0, 7));
        if (tb >= 5'd4) tb = tb + 5'd12;
        if (!(cdb_a_flg && tb == ta)) drive_cdb_b(tb, $urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
